// File: rtl/prefetch_buffer.sv
// prefetch_buffer: instruction prefetch queue with halfword realignment and flush discard.
module prefetch_buffer #(
   parameter logic [31:0] BOOT_ADDRESS    = 32'h0,
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en_i,
   input  logic        flush_i,
   input  logic [31:0] flush_addr_i,
   output logic        imem_req_o,
   input  logic        imem_gnt_i,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_rdata_o,
   output logic [31:0] instr_addr_o,
   output logic        instr_compressed_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   mem [DEPTH];
   logic [CW-1:0] wr_ptr, rd_ptr, count, outstanding, out_nxt, discard;
   logic [AW-1:0] rd_idx, nxt_idx;
   logic [31:0]   fetch_addr, instr_addr, head, next_word, parcel;
   logic          offset, head_ok, next_ok, comp, fire, consume, pop, push;

   assign count     = wr_ptr - rd_ptr;
   assign head_ok   = count != '0;
   assign next_ok   = count >= CW'(2);
   assign rd_idx    = rd_ptr[AW-1:0];
   assign nxt_idx   = rd_idx + AW'(1);
   assign head      = mem[rd_idx];
   assign next_word = mem[nxt_idx];
   assign parcel    = offset ? {next_word[15:0], head[31:16]} : head;
   assign comp      = parcel[1:0] != 2'b11;

   assign instr_valid_o      = head_ok && (comp || !offset || next_ok);
   assign instr_rdata_o      = head_ok ? parcel : '0;
   assign instr_compressed_o = head_ok && comp;
   assign instr_addr_o       = instr_addr;
   assign imem_addr_o        = fetch_addr;

   // every request reserves a queue slot, so responses can never overflow the queue
   assign imem_req_o = rst_n && fetch_en_i && !flush_i
                       && (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH))
                       && (outstanding < CW'(MAX_OUTSTANDING));
   assign fire    = imem_req_o && imem_gnt_i;
   assign out_nxt = outstanding + CW'(fire) - CW'(imem_rvalid_i);
   assign consume = instr_valid_o && instr_ready_i && !flush_i;
   assign pop     = consume && (offset || !comp);
   assign push    = imem_rvalid_i && discard == '0 && !flush_i;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
         discard     <= '0;
         offset      <= 1'b0;
         fetch_addr  <= BOOT_ADDRESS;
         instr_addr  <= BOOT_ADDRESS;
      end else begin
         outstanding <= out_nxt;
         if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fetch_addr <= {flush_addr_i[31:2], 2'b00};
            offset     <= flush_addr_i[1];
            instr_addr <= flush_addr_i;
            discard    <= out_nxt;
         end else begin
            if (fire) fetch_addr <= fetch_addr + 32'd4;
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (pop) rd_ptr <= rd_ptr + CW'(1);
            if (consume) begin
               offset     <= offset ^ comp;
               instr_addr <= instr_addr + (comp ? 32'd2 : 32'd4);
            end
            if (imem_rvalid_i && discard != '0) discard <= discard - CW'(1);
         end
      end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= imem_rdata_i;
endmodule

// File: tb/tb_prefetch_buffer.sv
// tb_prefetch_buffer: directed scoreboard bench with an in-order memory responder.
module tb_prefetch_buffer;
   logic        clk, rst_n, fetch_en_i, flush_i, imem_req_o, imem_gnt_i, imem_rvalid_i;
   logic        instr_valid_o, instr_ready_i, instr_compressed_o;
   logic [31:0] flush_addr_i, imem_addr_o, imem_rdata_i, instr_rdata_o, instr_addr_o;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        comp;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pend[$];
   logic [31:0] ovr[logic [31:0]];
   int          tests, fails, nfire, ncyc;
   logic        rsp_en;

   prefetch_buffer #(.BOOT_ADDRESS(32'h0), .DEPTH(4), .MAX_OUTSTANDING(2)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en_i), .flush_i(flush_i),
      .flush_addr_i(flush_addr_i), .imem_req_o(imem_req_o), .imem_gnt_i(imem_gnt_i),
      .imem_addr_o(imem_addr_o), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
      .instr_rdata_o(instr_rdata_o), .instr_addr_o(instr_addr_o),
      .instr_compressed_o(instr_compressed_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ovr.exists(a) ? ovr[a] : {a[29:0], 2'b11};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic expect_instr(input logic [31:0] a, input logic [31:0] d, input logic c);
      exp_q.push_back('{addr: a, data: d, comp: c});
   endtask

   task automatic expect_stream(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) expect_instr(base + 32'(4 * i), mem_word(base + 32'(4 * i)), 1'b0);
   endtask

   // one clock of memory behaviour: answer the oldest granted request, record new grants
   task automatic cyc();
      logic        f;
      logic [31:0] a;
      imem_rvalid_i = rsp_en && pend.size() > 0;
      imem_rdata_i  = imem_rvalid_i ? mem_word(pend[0]) : 32'h0;
      #1;
      f = imem_req_o && imem_gnt_i;
      a = imem_addr_o;
      @(posedge clk);
      if (imem_rvalid_i) void'(pend.pop_front());
      if (f) begin
         pend.push_back(a);
         nfire++;
      end
      ncyc++;
      @(negedge clk);
   endtask

   task automatic run(input string name, input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         cyc();
         c++;
      end
      chk(name, 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      instr_ready_i = 1'b0;
   endtask

   task automatic do_flush(input string name, input logic [31:0] a);
      flush_i      = 1'b1;
      flush_addr_i = a;
      #1;
      chk({name, "_req_in_flush"}, {31'b0, imem_req_o}, 32'h0);
      cyc();
      flush_i = 1'b0;
      chk({name, "_addr"}, instr_addr_o, a);
      chk({name, "_valid"}, {31'b0, instr_valid_o}, 32'h0);
   endtask

   task automatic settle();
      fetch_en_i    = 1'b0;
      instr_ready_i = 1'b0;
      rsp_en        = 1'b1;
      do_flush("settle", 32'hF000);
      repeat (4) cyc();
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && instr_valid_o && instr_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_instr: got addr %h, required no instruction", instr_addr_o);
            end else begin
               e = exp_q.pop_front();
               chk("instr_addr", instr_addr_o, e.addr);
               chk("instr_comp", {31'b0, instr_compressed_o}, {31'b0, e.comp});
               if (e.comp) chk("instr_rdata16", {16'h0, instr_rdata_o[15:0]}, {16'h0, e.data[15:0]});
               else chk("instr_rdata32", instr_rdata_o, e.data);
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1);
   end

   initial begin
      int n0;
      tests = 0; fails = 0; nfire = 0; ncyc = 0;
      rst_n = 1'b0; fetch_en_i = 1'b1; flush_i = 1'b0; flush_addr_i = '0;
      imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b1; rsp_en = 1'b1;
      fork monitor(); join_none
      repeat (2) @(negedge clk);
      chk("rst_req", {31'b0, imem_req_o}, 32'h0);
      chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
      chk("rst_rdata", instr_rdata_o, 32'h0);
      chk("rst_addr", instr_addr_o, 32'h0);
      chk("rst_comp", {31'b0, instr_compressed_o}, 32'h0);
      rst_n = 1'b1;

      // streaming from boot address, one instruction per cycle after two cycles
      expect_stream(32'h0, 8);
      n0 = ncyc;
      cyc();
      chk("stream_lat1_valid", {31'b0, instr_valid_o}, 32'h0);
      cyc();
      chk("stream_lat2_valid", {31'b0, instr_valid_o}, 32'h1);
      run("stream_drain", 30);
      chk("stream_cycles", 32'(ncyc - n0), 32'd10);
      settle();

      // compressed pair followed by a 32-bit instruction
      ovr[32'h1000] = 32'h0001_4501;
      ovr[32'h1004] = 32'h0000_0513;
      fetch_en_i = 1'b1;
      do_flush("comp_flush", 32'h1000);
      expect_instr(32'h1000, 32'h0001_4501, 1'b1);
      expect_instr(32'h1002, 32'h0513_0001, 1'b1);
      expect_instr(32'h1004, 32'h0000_0513, 1'b0);
      instr_ready_i = 1'b1;
      run("comp_drain", 30);
      settle();

      // 32-bit instruction straddling two words
      ovr[32'h100] = 32'h0513_1234;
      ovr[32'h104] = 32'h5678_0000;
      fetch_en_i = 1'b1;
      rsp_en = 1'b0;
      do_flush("mis_flush", 32'h102);
      repeat (3) cyc();
      chk("mis_pending", 32'(pend.size()), 32'd2);
      rsp_en = 1'b1;
      cyc();
      rsp_en = 1'b0;
      chk("mis_half_valid", {31'b0, instr_valid_o}, 32'h0);
      expect_instr(32'h102, 32'h0000_0513, 1'b0);
      rsp_en = 1'b1;
      instr_ready_i = 1'b1;
      run("mis_drain", 30);
      settle();

      // backpressure fills exactly DEPTH words, then drains without loss
      fetch_en_i = 1'b1;
      do_flush("bp_flush", 32'h2000);
      nfire = 0;
      repeat (20) cyc();
      chk("bp_fires", 32'(nfire), 32'd4);
      chk("bp_req_low", {31'b0, imem_req_o}, 32'h0);
      chk("bp_outstanding", 32'(pend.size()), 32'h0);
      chk("bp_valid", {31'b0, instr_valid_o}, 32'h1);
      expect_stream(32'h2000, 8);
      instr_ready_i = 1'b1;
      run("bp_drain", 40);
      settle();

      // flush while two responses are still pending
      fetch_en_i = 1'b1;
      rsp_en = 1'b0;
      do_flush("fl2_start", 32'h3000);
      repeat (3) cyc();
      chk("fl2_pending", 32'(pend.size()), 32'd2);
      do_flush("fl2_flush", 32'h200);
      rsp_en = 1'b1;
      expect_stream(32'h200, 4);
      instr_ready_i = 1'b1;
      run("fl2_drain", 40);
      settle();

      // flush coinciding with a response and an armed grant: one left to discard
      fetch_en_i = 1'b1;
      rsp_en = 1'b0;
      do_flush("fl1_start", 32'h4000);
      cyc();
      chk("fl1_prior", 32'(pend.size()), 32'd1);
      cyc();
      rsp_en = 1'b1;
      do_flush("fl1_flush", 32'h500);
      chk("fl1_left", 32'(pend.size()), 32'd1);
      expect_stream(32'h500, 3);
      instr_ready_i = 1'b1;
      run("fl1_drain", 40);
      settle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
